// File: rtl/mash111_noise_cancel_if.sv
// Sample-side bus of the MASH 1-1-1 noise-cancellation stage: carry inputs,
// integer word and the registered modulus outputs.
interface mash111_noise_cancel_if #(
  parameter int unsigned P_INT_WIDTH = 8
);
  logic                   i_en;
  logic                   i_q1;
  logic                   i_q2;
  logic                   i_q3;
  logic [P_INT_WIDTH-1:0] i_int;
  logic [3:0]             o_y;
  logic [P_INT_WIDTH-1:0] o_div;
  logic                   o_valid;
  logic                   o_sat;

  // Producer side: drives carries and integer word, observes the modulus.
  modport master (
    output i_en, i_q1, i_q2, i_q3, i_int,
    input  o_y, o_div, o_valid, o_sat
  );

  // Noise-cancellation stage side.
  modport slave (
    input  i_en, i_q1, i_q2, i_q3, i_int,
    output o_y, o_div, o_valid, o_sat
  );
endinterface

// File: rtl/mash111_noise_cancel.sv
// MASH 1-1-1 noise-cancellation network: realigns the skewed stage carries,
// forms y = c1*z^-2 + c2*(1-z^-1)*z^-1 + c3*(1-z^-1)^2 and adds it to N.
module mash111_noise_cancel #(
  parameter int unsigned P_INT_WIDTH  = 8,
  parameter int unsigned P_STAGE_SKEW = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  mash111_noise_cancel_if.slave  bus
);

  localparam int unsigned D1    = 2 * P_STAGE_SKEW;
  localparam int unsigned D2    = P_STAGE_SKEW;
  localparam int unsigned FILL  = 2 * P_STAGE_SKEW + 2;
  localparam int unsigned CNT_W = $clog2(FILL + 1);
  localparam int unsigned SUM_W = P_INT_WIDTH + 2;

  logic a1_c;
  logic a2_c;
  logic a3_c;

  // Stage 1 carry arrives earliest, so it is held back by two skews.
  generate
    if (D1 == 0) begin : g_d1_wire
      assign a1_c = bus.i_q1;
    end else begin : g_d1_sr
      logic [D1-1:0] sr;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          sr <= '0;
        end else if (bus.i_en) begin
          sr[0] <= bus.i_q1;
          for (int i = 1; i < int'(D1); i++) begin
            sr[i] <= sr[i-1];
          end
        end
      end
      assign a1_c = sr[D1-1];
    end
  endgenerate

  generate
    if (D2 == 0) begin : g_d2_wire
      assign a2_c = bus.i_q2;
    end else begin : g_d2_sr
      logic [D2-1:0] sr;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          sr <= '0;
        end else if (bus.i_en) begin
          sr[0] <= bus.i_q2;
          for (int i = 1; i < int'(D2); i++) begin
            sr[i] <= sr[i-1];
          end
        end
      end
      assign a2_c = sr[D2-1];
    end
  endgenerate

  assign a3_c = bus.i_q3;

  logic a1_d1, a1_d2;
  logic a2_d1, a2_d2;
  logic a3_d1, a3_d2;
  logic [CNT_W-1:0] fill_cnt;

  logic [3:0]             y_c;
  logic [SUM_W-1:0]       sum_c;
  logic [P_INT_WIDTH-1:0] div_c;
  logic                   sat_c;
  logic                   full_c;

  // Mod-16 arithmetic equals 4-bit two's complement; range -3..+4 never wraps.
  always_comb begin
    y_c = 4'(a1_d2)
        + 4'(a2_d1) - 4'(a2_d2)
        + 4'(a3_c) - 4'({a3_d1, 1'b0}) + 4'(a3_d2);
  end

  // |y| <= 4 keeps the sum inside [-4, 2^W+3]: top bit flags negative, next bit overflow.
  always_comb begin
    sum_c = {2'b00, bus.i_int} + {{(SUM_W-4){y_c[3]}}, y_c};
    div_c = sum_c[P_INT_WIDTH-1:0];
    sat_c = 1'b0;
    if (sum_c[SUM_W-1]) begin
      div_c = '0;
      sat_c = 1'b1;
    end else if (sum_c[SUM_W-2]) begin
      div_c = '1;
      sat_c = 1'b1;
    end
  end

  assign full_c = (fill_cnt == CNT_W'(FILL));

  // History, fill counter and output registers; o_valid only marks fresh samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a1_d1       <= 1'b0;
      a1_d2       <= 1'b0;
      a2_d1       <= 1'b0;
      a2_d2       <= 1'b0;
      a3_d1       <= 1'b0;
      a3_d2       <= 1'b0;
      fill_cnt    <= '0;
      bus.o_y     <= '0;
      bus.o_div   <= '0;
      bus.o_sat   <= 1'b0;
      bus.o_valid <= 1'b0;
    end else if (bus.i_en) begin
      a1_d1       <= a1_c;
      a1_d2       <= a1_d1;
      a2_d1       <= a2_c;
      a2_d2       <= a2_d1;
      a3_d1       <= a3_c;
      a3_d2       <= a3_d1;
      if (!full_c) begin
        fill_cnt <= fill_cnt + CNT_W'(1);
      end
      bus.o_y     <= y_c;
      bus.o_div   <= div_c;
      bus.o_sat   <= sat_c;
      bus.o_valid <= full_c;
    end else begin
      bus.o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mash111_noise_cancel.sv
// Randomised and directed bench for mash111_noise_cancel against a
// sample-history model of the MASH 1-1-1 cancellation network.
module tb_mash111_noise_cancel;

  localparam int W    = 8;
  localparam int S    = 1;
  localparam int FILL = 2 * S + 2;
  localparam int MAXV = (1 << W) - 1;

  logic clk;
  logic rst;

  mash111_noise_cancel_if #(.P_INT_WIDTH(W)) bus ();

  mash111_noise_cancel #(
    .P_INT_WIDTH  (W),
    .P_STAGE_SKEW (S)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Accepted raw carries since the last reset, oldest first.
  int h1[$];
  int h2[$];
  int h3[$];

  int m_y     = 0;
  int m_div   = 0;
  int m_sat   = 0;
  int m_valid = 0;

  longint sum_dut_y = 0;
  longint sum_ref_y = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tap(input int which, input int k);
    if (k < 0) return 0;
    case (which)
      1:       return h1[k];
      2:       return h2[k];
      default: return h3[k];
    endcase
  endfunction

  function automatic int dut_y();
    return int'($signed(bus.o_y));
  endfunction

  // One clock: apply inputs, advance the reference, compare every output.
  task automatic step(input bit r, input bit en, input bit q1, input bit q2,
                      input bit q3, input int iv);
    int n;
    int s;
    rst       = r;
    bus.i_en  = en;
    bus.i_q1  = q1;
    bus.i_q2  = q2;
    bus.i_q3  = q3;
    bus.i_int = W'(iv);
    @(posedge clk);
    #1;
    if (r) begin
      h1.delete(); h2.delete(); h3.delete();
      m_y = 0; m_div = 0; m_sat = 0; m_valid = 0;
    end else if (en) begin
      h1.push_back(int'(q1));
      h2.push_back(int'(q2));
      h3.push_back(int'(q3));
      n = h3.size() - 1;
      // Realigned taps: stage 1 lags 2S samples, stage 2 lags S samples.
      m_y = tap(1, n - 2 - 2*S)
          + tap(2, n - 1 - S) - tap(2, n - 2 - S)
          + tap(3, n) - 2 * tap(3, n - 1) + tap(3, n - 2);
      m_valid = (n >= FILL) ? 1 : 0;
      s = iv + m_y;
      if (s < 0) begin
        m_div = 0; m_sat = 1;
      end else if (s > MAXV) begin
        m_div = MAXV; m_sat = 1;
      end else begin
        m_div = s; m_sat = 0;
      end
    end else begin
      m_valid = 0;
    end
    check("o_y",     dut_y(),            m_y);
    check("o_div",   int'(bus.o_div),    m_div);
    check("o_sat",   int'(bus.o_sat),    m_sat);
    check("o_valid", int'(bus.o_valid),  m_valid);
    if (m_valid == 1) begin
      sum_dut_y += dut_y();
      sum_ref_y += m_y;
    end
  endtask

  task automatic rand_step(input int rst_odds);
    bit r;
    r = (rst_odds > 0) && ($urandom_range(0, rst_odds - 1) == 0);
    step(r, $urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom),
         1'($urandom), int'($urandom_range(0, MAXV)));
  endtask

  bit saw_top_sat;

  initial begin
    rst = 1'b1;
    bus.i_en = 1'b1; bus.i_q1 = 1'b0; bus.i_q2 = 1'b0; bus.i_q3 = 1'b0;
    bus.i_int = '0;

    // Reset, with i_en high to exercise reset priority.
    step(1, 1, 0, 0, 0, 20);
    check("rst_y",     dut_y(),           0);
    check("rst_div",   int'(bus.o_div),   0);
    check("rst_valid", int'(bus.o_valid), 0);

    // Zero carries: valid rises on the (FILL+1)th enabled edge.
    for (int i = 0; i <= FILL; i++) begin
      step(0, 1, 0, 0, 0, 20);
      check("fill_valid", int'(bus.o_valid), (i == FILL) ? 1 : 0);
    end
    check("zero_div", int'(bus.o_div), 20);

    // Constant stage-1 carry settles at y=+1.
    for (int i = 0; i < FILL + 1; i++) step(0, 1, 1, 0, 0, 20);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0, 20);
      check("c1_y",   dut_y(),         1);
      check("c1_div", int'(bus.o_div), 21);
    end
    for (int i = 0; i < FILL + 2; i++) step(0, 1, 0, 0, 0, 20);

    // Single stage-3 impulse: +1, -2, +1, 0.
    step(0, 1, 0, 0, 1, 20); check("imp_div0", int'(bus.o_div), 21);
    step(0, 1, 0, 0, 0, 20); check("imp_div1", int'(bus.o_div), 18);
    step(0, 1, 0, 0, 0, 20); check("imp_div2", int'(bus.o_div), 21);
    step(0, 1, 0, 0, 0, 20); check("imp_div3", int'(bus.o_div), 20);

    // Low clamp: N=0 with the -2 tap.
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    check("lo_div", int'(bus.o_div), 0);
    check("lo_sat", int'(bus.o_sat), 1);
    for (int i = 0; i < FILL; i++) step(0, 1, 0, 0, 0, 20);

    // High clamp: N=255, q1 held high, q2 steps up giving y=+2.
    for (int i = 0; i < FILL + 1; i++) step(0, 1, 1, 0, 0, 255);
    saw_top_sat = 1'b0;
    for (int i = 0; i < FILL + 1; i++) begin
      step(0, 1, 1, 1, 0, 255);
      if (dut_y() == 2 && bus.o_div == 8'hFF && bus.o_sat) saw_top_sat = 1'b1;
    end
    check("hi_sat_seen", int'(saw_top_sat), 1);
    for (int i = 0; i < FILL + 2; i++) step(0, 1, 0, 0, 0, 20);

    // Enable drop inside an impulse: outputs hold, taps resume in order.
    step(0, 1, 0, 0, 1, 20); check("gap_y0", dut_y(), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 1, 99);
      check("gap_hold_y",   dut_y(),           1);
      check("gap_hold_val", int'(bus.o_valid), 0);
    end
    step(0, 1, 0, 0, 0, 20); check("gap_y1", dut_y(), -2);
    step(0, 1, 0, 0, 0, 20); check("gap_y2", dut_y(), 1);
    step(0, 1, 0, 0, 0, 20); check("gap_y3", dut_y(), 0);

    // Random streams, then a mid-run reset and refill.
    for (int i = 0; i < 300; i++) rand_step(0);
    step(1, 1, 1, 1, 1, 77);
    check("mid_rst_y",   dut_y(),         0);
    check("mid_rst_div", int'(bus.o_div), 0);
    for (int i = 0; i < FILL; i++) begin
      step(0, 1, 1'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, MAXV)));
      check("refill_valid", int'(bus.o_valid), 0);
    end

    // Long random run with occasional resets.
    for (int i = 0; i < 3000; i++) rand_step(250);
    check("mean_y_sum", int'(sum_dut_y), int'(sum_ref_y));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
